dma_burst_sequencer: RTL and testbench

- Command front-end that sits directly upstream of one DMA channel: the read path (read_*) or the write path (write_*).
- Accepts a long transfer command (base address plus total beat count) on a valid/ready handshake.
- Splits the command into AXI-legal INCR bursts: at most MAX_BURST beats each, never crossing a 4 KiB boundary.
- Issues each burst to the channel's start/addr/len/size interface, sequencing on the channel's busy flag.
- Pulses done_o when the final burst completes. One instance is used per direction.

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_burst_sequencer_if.sv | 30 +++
 rtl/dma_burst_calc.sv | 33 +++
 rtl/dma_burst_sequencer.sv | 121 ++++++++++++
 tb/tb_dma_burst_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA burst sequencer: AXI constants, size helper and FSM encoding.
package dma_pkg;

  localparam int unsigned AXI_BOUNDARY   = 4096;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  // Ceiling log2, used to derive the AXI size field from the data width in bytes.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_CALC  = 3'd1,
    SEQ_START = 3'd2,
    SEQ_ACK   = 3'd3,
    SEQ_RUN   = 3'd4,
    SEQ_DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/dma_burst_sequencer_if.sv
// Command and channel-facing signals of one burst sequencer instance.
interface dma_burst_sequencer_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BEATS_W = 24
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [ADDR_W-1:0]  cmd_addr_i;
  logic [BEATS_W-1:0] cmd_beats_i;
  logic               start_o;
  logic [ADDR_W-1:0]  addr_o;
  logic [7:0]         len_o;
  logic [2:0]         size_o;
  logic               chan_busy_i;
  logic               busy_o;
  logic               done_o;
  logic [15:0]        burst_cnt_o;

  // Sequencer side.
  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_beats_i, chan_busy_i,
    output cmd_ready_o, start_o, addr_o, len_o, size_o, busy_o, done_o, burst_cnt_o
  );

  // Command producer / channel side.
  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_beats_i, chan_busy_i,
    input  cmd_ready_o, start_o, addr_o, len_o, size_o, busy_o, done_o, burst_cnt_o
  );
endinterface

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: largest INCR burst from cur_addr that respects MAX_BURST,
// the remaining beats and the next 4 KiB boundary.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BEATS_W   = 24,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned SIZE      = 3
) (
  input  logic [ADDR_W-1:0]  cur_addr,
  input  logic [BEATS_W-1:0] rem_beats,
  output logic [8:0]         n,
  output logic [ADDR_W-1:0]  next_addr
);

  localparam int unsigned NW = 9;
  localparam int unsigned RW = 13;

  logic [RW-1:0] room;
  logic [NW-1:0] cap;

  always_comb begin
    room = (RW'(AXI_BOUNDARY) - {1'b0, cur_addr[11:0]}) >> SIZE;
    if (rem_beats < BEATS_W'(MAX_BURST)) cap = NW'(rem_beats);
    else                                 cap = NW'(MAX_BURST);
    // cur_addr is always size-aligned, so room is at least one beat.
    if (RW'(cap) > room) n = NW'(room);
    else                 n = cap;
    next_addr = cur_addr + (ADDR_W'(n) << SIZE);
  end

endmodule

// File: rtl/dma_burst_sequencer.sv
// Splits a long DMA command into AXI-legal INCR bursts and issues them one at a time
// to a single channel, sequencing on the channel busy flag.
module dma_burst_sequencer
  import dma_pkg::*;
#(
  parameter int unsigned DMA_DATA_WIDTH_SRC = 64,
  parameter int unsigned DMA_AXI_ADDR_WIDTH = 32,
  parameter int unsigned BEATS_WIDTH        = 24,
  parameter int unsigned MAX_BURST          = 256
) (
  input logic                   m_axi_aclk,
  input logic                   m_axi_areset,
  dma_burst_sequencer_if.slave  bus
);

  localparam int unsigned BYTES   = DMA_DATA_WIDTH_SRC / 8;
  localparam int unsigned SIZE    = clog2(BYTES);
  localparam int unsigned ADDR_W  = DMA_AXI_ADDR_WIDTH;
  localparam int unsigned BEATS_W = BEATS_WIDTH;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  seq_state_e         state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         len_q;
  logic [15:0]        burst_cnt_q;
  logic [ADDR_W-1:0]  cur_addr_q;
  logic [BEATS_W-1:0] rem_q;
  logic               accept;
  logic [8:0]         n;
  logic [ADDR_W-1:0]  next_addr;

  dma_burst_calc #(
    .ADDR_W    (ADDR_W),
    .BEATS_W   (BEATS_W),
    .MAX_BURST (MAX_BURST),
    .SIZE      (SIZE)
  ) u_calc (
    .cur_addr  (cur_addr_q),
    .rem_beats (rem_q),
    .n         (n),
    .next_addr (next_addr)
  );

  assign accept = (state_q == SEQ_IDLE) && bus.cmd_valid_i && cmd_ready_q;

  // Next state and next values of the registered control outputs.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    unique case (state_q)
      SEQ_IDLE:  if (accept) state_d = (bus.cmd_beats_i == '0) ? SEQ_DONE : SEQ_CALC;
      SEQ_CALC:  state_d = SEQ_START;
      SEQ_START: state_d = SEQ_ACK;
      SEQ_ACK:   if (bus.chan_busy_i) state_d = SEQ_RUN;
      SEQ_RUN:   if (!bus.chan_busy_i) state_d = (rem_q == '0) ? SEQ_DONE : SEQ_CALC;
      SEQ_DONE:  state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
    cmd_ready_d = (state_d == SEQ_IDLE);
    start_d     = (state_d == SEQ_START);
    done_d      = (state_d == SEQ_DONE);
    busy_d      = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q     <= SEQ_IDLE;
      cmd_ready_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      start_q     <= start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Burst datapath: command latch, per-burst bookkeeping and the burst counter.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      addr_q      <= '0;
      len_q       <= '0;
      burst_cnt_q <= '0;
      cur_addr_q  <= '0;
      rem_q       <= '0;
    end else begin
      if (accept) begin
        cur_addr_q  <= bus.cmd_addr_i & ALIGN_MASK;
        rem_q       <= bus.cmd_beats_i;
        burst_cnt_q <= '0;
      end
      if (state_q == SEQ_CALC) begin
        addr_q     <= cur_addr_q;
        len_q      <= 8'(n - 9'd1);
        cur_addr_q <= next_addr;
        rem_q      <= rem_q - BEATS_W'(n);
      end
      if (state_q == SEQ_CALC && state_d == SEQ_START) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.start_o     = start_q;
  assign bus.done_o      = done_q;
  assign bus.busy_o      = busy_q;
  assign bus.addr_o      = addr_q;
  assign bus.len_o       = len_q;
  assign bus.burst_cnt_o = burst_cnt_q;
  assign bus.size_o      = 3'(SIZE);

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Randomized self-checking bench for dma_burst_sequencer against an arithmetic burst-split model.
module tb_dma_burst_sequencer;

  localparam int unsigned BYTES = 8;
  localparam int unsigned MAXB  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dma_burst_sequencer_if #(.ADDR_W(32), .BEATS_W(24)) bus ();

  dma_burst_sequencer #(
    .DMA_DATA_WIDTH_SRC (64),
    .DMA_AXI_ADDR_WIDTH (32),
    .BEATS_WIDTH        (24),
    .MAX_BURST          (256)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_beats_i = '0;
    bus.chan_busy_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready_o !== 1'b0 || bus.start_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.done_o !== 1'b0 || bus.addr_o !== 32'h0 || bus.len_o !== 8'h0 ||
        bus.burst_cnt_o !== 16'h0 || bus.size_o !== 3'd3) begin
      $display("FAIL reset_outputs: rdy=%b st=%b bsy=%b dn=%b addr=%h len=%h cnt=%0d size=%0d, required all 0 and size 3",
               bus.cmd_ready_o, bus.start_o, bus.busy_o, bus.done_o, bus.addr_o, bus.len_o,
               bus.burst_cnt_o, bus.size_o);
      n_err++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      $display("FAIL reset_release: rdy=%b bsy=%b, required rdy=1 bsy=0", bus.cmd_ready_o, bus.busy_o);
      n_err++;
    end
  endtask

  // Issues one command, plays the channel and checks every burst against the model.
  task automatic run_cmd(input string name, input logic [31:0] addr, input logic [23:0] beats,
                         input int ack_dly, input int hold, input bit noise);
    logic [31:0] ea[$];
    logic [7:0]  el[$];
    longint unsigned a, rem, room, nb;
    int k, acc_k, drop_k, raise_at, drop_at, ns, lat;
    bit done, got;
    a   = longint'(addr) & ~longint'(BYTES - 1);
    rem = longint'(beats);
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / BYTES;
      nb = rem;
      if (nb > MAXB) nb = MAXB;
      if (nb > room) nb = room;
      ea.push_back(32'(a));
      el.push_back(8'(nb - 1));
      a   = (a + nb * BYTES) % (64'd1 << 32);
      rem = rem - nb;
    end

    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = addr;
    bus.cmd_beats_i = beats;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      $display("FAIL %s_accept: cmd_ready_o never high, required 1 within 20 cycles", name);
      n_err++;
      bus.cmd_valid_i = 1'b0;
      return;
    end

    acc_k = 0; k = 0; ns = 0; drop_k = 0; raise_at = -1; drop_at = -1; done = 1'b0;
    while (!done && k < 6000) begin
      @(negedge clk);
      k++;
      bus.cmd_valid_i = 1'b0;
      if (bus.start_o === 1'b1) begin
        lat = (ns == 0) ? (k - acc_k) : (k - drop_k);
        n_cmp++;
        if (ns >= ea.size()) begin
          $display("FAIL %s_burst%0d: extra start addr=%h len=%0d, required only %0d bursts",
                   name, ns, bus.addr_o, bus.len_o, ea.size());
          n_err++;
        end else if (bus.addr_o !== ea[ns] || bus.len_o !== el[ns] || lat != 2 || bus.busy_o !== 1'b1) begin
          $display("FAIL %s_burst%0d: addr=%h len=%0d lat=%0d busy=%b, required addr=%h len=%0d lat=2 busy=1",
                   name, ns, bus.addr_o, bus.len_o, lat, bus.busy_o, ea[ns], el[ns]);
          n_err++;
        end
        ns++;
        raise_at = k + ack_dly;
        drop_at  = raise_at + hold;
      end
      if (k == raise_at) bus.chan_busy_i = 1'b1;
      if (k == drop_at) begin
        bus.chan_busy_i = 1'b0;
        drop_k = k;
      end
      if (bus.done_o === 1'b1) begin
        done = 1'b1;
        lat = (ns != 0) ? (k - drop_k) : (k - acc_k);
        n_cmp++;
        if (lat != 1 || ns != ea.size() || int'(bus.burst_cnt_o) != ea.size() || bus.busy_o !== 1'b1) begin
          $display("FAIL %s_done: lat=%0d starts=%0d cnt=%0d busy=%b, required lat=1 starts=%0d cnt=%0d busy=1",
                   name, lat, ns, bus.burst_cnt_o, bus.busy_o, ea.size(), ea.size());
          n_err++;
        end
      end else if (noise && $urandom_range(3) == 0) begin
        n_cmp++;
        if (bus.cmd_ready_o !== 1'b0) begin
          $display("FAIL %s_ready_while_busy: cmd_ready_o=%b, required 0", name, bus.cmd_ready_o);
          n_err++;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = $urandom;
        bus.cmd_beats_i = 24'($urandom_range(1, 50));
      end
    end
    bus.cmd_valid_i = 1'b0;
    bus.chan_busy_i = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: done_o not seen after %0d cycles, required done_o", name, k);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      $display("FAIL %s_idle_after: rdy=%b bsy=%b dn=%b, required rdy=1 bsy=0 dn=0",
               name, bus.cmd_ready_o, bus.busy_o, bus.done_o);
      n_err++;
    end
  endtask

  task automatic test_single();
    run_cmd("single", 32'h0000_1000, 24'd16, 1, 3, 1'b0);
  endtask

  task automatic test_4k_split();
    run_cmd("split4k", 32'h0000_0FC0, 24'd20, 2, 2, 1'b0);
  endtask

  task automatic test_max_burst();
    run_cmd("maxburst", 32'h0000_0000, 24'd600, 1, 4, 1'b0);
  endtask

  task automatic test_zero_beats();
    run_cmd("zero", 32'h0000_2340, 24'd0, 1, 1, 1'b0);
  endtask

  task automatic test_slow_channel();
    run_cmd("slow", 32'h0000_3F00, 24'd300, 5, 40, 1'b1);
  endtask

  task automatic test_wrap();
    run_cmd("wrap", 32'hFFFF_FFC5, 24'd30, 1, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen, bad;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = 32'h0;
    bus.cmd_beats_i = 24'd600;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.start_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      $display("FAIL rstmid_start: start_o not seen, required a first burst");
      n_err++;
    end
    @(negedge clk);
    bus.chan_busy_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.start_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) begin
      $display("FAIL rstmid_async: st=%b bsy=%b dn=%b rdy=%b, required all 0",
               bus.start_o, bus.busy_o, bus.done_o, bus.cmd_ready_o);
      n_err++;
    end
    bus.chan_busy_i = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.start_o !== 1'b0 || bus.busy_o !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      $display("FAIL rstmid_hold: activity during reset, required start_o=0 busy_o=0");
      n_err++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready_o !== 1'b1 || bus.burst_cnt_o !== 16'd0) begin
      $display("FAIL rstmid_release: rdy=%b cnt=%0d, required rdy=1 cnt=0", bus.cmd_ready_o, bus.burst_cnt_o);
      n_err++;
    end
    run_cmd("after_rst", 32'h0000_0F80, 24'd40, 1, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [23:0] beats;
    for (int i = 0; i < 24; i++) begin
      addr = $urandom;
      if ($urandom_range(2) == 0) addr[11:0] = 12'(4096 - 8 * $urandom_range(1, 40));
      case ($urandom_range(4))
        0:       beats = 24'd0;
        1:       beats = 24'($urandom_range(1, 8));
        2:       beats = 24'($urandom_range(200, 700));
        default: beats = 24'($urandom_range(1, 300));
      endcase
      run_cmd("random", addr, beats, $urandom_range(1, 4), $urandom_range(1, 10), 1'($urandom_range(1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_cmd("b2b", 32'h0000_0FF0 + 32'(i * 8), 24'($urandom_range(1, 40)), 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_4k_split();
    test_max_burst();
    test_zero_beats();
    test_slow_channel();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
